writeback_scoreboard: RTL
=========================

Name: writeback_scoreboard

Overview:
- Producer side of the integer register file write port.
- Tracks destination registers that have a pending result (scoreboard) and stalls issue on RAW/WAW hazards.
- Arbitrates completions from the ALU (unbuffered, top priority) and the load unit (buffered FIFO) onto the single register-file write port.
- Sits between decode/issue, the execute/memory units and the register file.

Parameters:
XLEN, 64, data width of register values
NREGS, 32, number of architectural registers (index width 5)
MQ_DEPTH, 4, load-writeback FIFO depth (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
iss_valid  in  1  decode presents an instruction
iss_rs1  in  5  source register 1
iss_rs2  in  5  source register 2
iss_rd  in  5  destination register
iss_writes_rd  in  1  instruction writes iss_rd
iss_ready  out  1  issue may proceed (combinational)
alu_wb_valid  in  1  ALU result valid (always accepted)
alu_wb_rd  in  5  ALU destination
alu_wb_data  in  XLEN  ALU result
mem_wb_valid  in  1  load result valid
mem_wb_rd  in  5  load destination
mem_wb_data  in  XLEN  load data
mem_wb_ready  out  1  FIFO can accept a load result
rf_write_en  out  1  drives register-file write enable
rf_write_reg  out  5  drives register-file write index
rf_write_data  out  XLEN  drives register-file write data
busy_vec  out  NREGS  pending-write bit per register (bit 0 always 0)
wb_err  out  1  sticky: writeback to a non-busy register

Behaviour:
- Reset (while reset high, and on the edge after): busy_vec=0, FIFO empty, rf_write_en=0, rf_write_reg=0, rf_write_data=0, wb_err=0. iss_ready=0 and mem_wb_ready=0 while reset is high.
- iss_ready = !reset & !(rs1!=0 & busy[rs1]) & !(rs2!=0 & busy[rs2]) & !(iss_writes_rd & rd!=0 & busy[rd]).
  - Depends only on iss_* inputs and registered busy bits.
  - No bypass: a register clearing this cycle still stalls.
- Issue accept = iss_valid & iss_ready. If iss_writes_rd & rd!=0, busy[rd] is set on that edge. rd=0 never becomes busy.
- mem_wb_ready = !reset & (count < MQ_DEPTH).
  - Push on mem_wb_valid & mem_wb_ready.
  - A push while full is dropped (protocol violation; do not corrupt state).
- Arbitration, evaluated each cycle:
  - If alu_wb_valid, select the ALU.
  - Else if FIFO is non-empty, select the FIFO head and pop it.
  - Else select nothing.
  - The ALU starves the FIFO by design; the issue stall bounds this.
- Selected entry with rd!=0 is registered onto rf_write_*, with rf_write_en=1 the following cycle.
  - Selected entry with rd=0 is consumed, never written, and does not touch busy or wb_err.
  - When nothing is selected, rf_write_en=0 and rf_write_reg/rf_write_data hold their previous values.
- Latency:
  - ALU result at edge N -> rf_write_en high in cycle N+1 -> register file updated and busy[rd] cleared at edge N+2.
  - A load entering an empty FIFO at edge N is selected in cycle N+1 if no ALU result is present, so busy clears at edge N+3.
- Busy clear happens on the edge where rf_write_en=1 for rf_write_reg.
  - If an issue sets the same register on that edge, set wins.
  - This cannot occur legally because of the WAW stall; it must still resolve as set.
- wb_err is set when a selected entry with rd!=0 finds busy[rd]=0 at selection time. The write still proceeds. wb_err is cleared only by reset.
- Push and pop in the same cycle are both performed; count is unchanged. Pointers wrap modulo MQ_DEPTH.
- Reset asserted mid-operation discards FIFO contents and the pending write. No write is presented in the cycle after reset.

Test Plan:
- Reset then idle: busy_vec=0, rf_write_en=0, iss_ready=1 for rs1=rs2=rd=0, mem_wb_ready=1.
- Issue rd=5 (writes_rd=1).
  - Next cycle, issue with rs1=5 gives iss_ready=0.
  - ALU wb rd=5 data=0x1234 -> rf_write_en=1, reg=5, data=0x1234 one cycle later; busy[5]=0 the cycle after that, and iss_ready returns to 1.
- Issue rd=0 -> busy_vec stays 0. ALU wb rd=0 -> rf_write_en stays 0 and wb_err stays 0.
- Fill FIFO: issue rd=1..4, then push 4 loads with alu_wb_valid held high.
  - mem_wb_ready=0 after the 4th push.
  - Drop alu_wb_valid -> writes appear in order 1,2,3,4 on consecutive cycles, and mem_wb_ready returns to 1 after the first pop.
- Simultaneous ALU wb rd=7 and load wb rd=8 (both busy): write rd=7 first cycle, rd=8 next cycle, both busy bits cleared in order.
- Error and reset:
  - ALU wb to non-busy rd=9 -> wb_err=1 and the write still occurs.
  - Assert reset with 2 entries queued -> FIFO empty, wb_err=0, busy_vec=0, and no rf_write_en after reset.

Source files
------------

// File: rtl/writeback_scoreboard_if.sv
// Issue, execute-writeback and register-file write signals of the writeback scoreboard.
// master = surrounding pipeline/environment, slave = the scoreboard itself.
interface writeback_scoreboard_if #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned NREGS = 32
);
   localparam int unsigned RegW = $clog2(NREGS);

   logic             iss_valid;
   logic [RegW-1:0]  iss_rs1;
   logic [RegW-1:0]  iss_rs2;
   logic [RegW-1:0]  iss_rd;
   logic             iss_writes_rd;
   logic             iss_ready;
   logic             alu_wb_valid;
   logic [RegW-1:0]  alu_wb_rd;
   logic [XLEN-1:0]  alu_wb_data;
   logic             mem_wb_valid;
   logic [RegW-1:0]  mem_wb_rd;
   logic [XLEN-1:0]  mem_wb_data;
   logic             mem_wb_ready;
   logic             rf_write_en;
   logic [RegW-1:0]  rf_write_reg;
   logic [XLEN-1:0]  rf_write_data;
   logic [NREGS-1:0] busy_vec;
   logic             wb_err;

   modport master (
      output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_writes_rd,
      output alu_wb_valid, alu_wb_rd, alu_wb_data,
      output mem_wb_valid, mem_wb_rd, mem_wb_data,
      input  iss_ready, mem_wb_ready, rf_write_en, rf_write_reg, rf_write_data,
      input  busy_vec, wb_err
   );

   modport slave (
      input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_writes_rd,
      input  alu_wb_valid, alu_wb_rd, alu_wb_data,
      input  mem_wb_valid, mem_wb_rd, mem_wb_data,
      output iss_ready, mem_wb_ready, rf_write_en, rf_write_reg, rf_write_data,
      output busy_vec, wb_err
   );
endinterface

// File: rtl/writeback_scoreboard.sv
// Register scoreboard with RAW/WAW issue stall, plus ALU-over-load arbitration onto the
// single register-file write port. Loads are buffered in a small FIFO; ALU results are not.
module writeback_scoreboard #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned MQ_DEPTH = 4
) (
   input logic                  clk,
   input logic                  reset,
   writeback_scoreboard_if.slave bus
);
   localparam int unsigned RegW = $clog2(NREGS);
   localparam int unsigned PtrW = $clog2(MQ_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [NREGS-1:0] busy_q, busy_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             rf_we_q, rf_we_d;
   logic [RegW-1:0]  rf_reg_q, rf_reg_d;
   logic [XLEN-1:0]  rf_data_q, rf_data_d;
   logic             wb_err_q, wb_err_d;

   logic [RegW-1:0]  fifo_rd_q   [MQ_DEPTH];
   logic [XLEN-1:0]  fifo_data_q [MQ_DEPTH];

   logic             iss_ready, iss_accept, mem_ready, push, pop;
   logic             sel_valid;
   logic [RegW-1:0]  sel_rd;
   logic [XLEN-1:0]  sel_data;

   // Stall uses only registered busy bits: a register retiring this cycle still stalls.
   always_comb begin
      iss_ready = !reset
                  && !((bus.iss_rs1 != '0) && busy_q[bus.iss_rs1])
                  && !((bus.iss_rs2 != '0) && busy_q[bus.iss_rs2])
                  && !(bus.iss_writes_rd && (bus.iss_rd != '0) && busy_q[bus.iss_rd]);
      iss_accept = bus.iss_valid && iss_ready;
      mem_ready  = !reset && (count_q < CntW'(MQ_DEPTH));
      push       = bus.mem_wb_valid && mem_ready;
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      pop       = 1'b0;
      if (bus.alu_wb_valid) begin
         sel_valid = 1'b1;
         sel_rd    = bus.alu_wb_rd;
         sel_data  = bus.alu_wb_data;
      end else if (count_q != '0) begin
         sel_valid = 1'b1;
         sel_rd    = fifo_rd_q[rd_ptr_q];
         sel_data  = fifo_data_q[rd_ptr_q];
         pop       = 1'b1;
      end
   end

   always_comb begin
      rf_we_d   = 1'b0;
      rf_reg_d  = rf_reg_q;
      rf_data_d = rf_data_q;
      wb_err_d  = wb_err_q;
      if (sel_valid && (sel_rd != '0)) begin
         rf_we_d   = 1'b1;
         rf_reg_d  = sel_rd;
         rf_data_d = sel_data;
         if (!busy_q[sel_rd]) wb_err_d = 1'b1;
      end

      // Set after clear so a same-edge re-issue keeps the register busy.
      busy_d = busy_q;
      if (rf_we_q) busy_d[rf_reg_q] = 1'b0;
      if (iss_accept && bus.iss_writes_rd && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
      busy_d[0] = 1'b0;

      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push) - CntW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rf_we_q   <= 1'b0;
         rf_reg_q  <= '0;
         rf_data_q <= '0;
         wb_err_q  <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rf_we_q   <= rf_we_d;
         rf_reg_q  <= rf_reg_d;
         rf_data_q <= rf_data_d;
         wb_err_q  <= wb_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= bus.mem_wb_rd;
         fifo_data_q[wr_ptr_q] <= bus.mem_wb_data;
      end
   end

   assign bus.iss_ready     = iss_ready;
   assign bus.mem_wb_ready  = mem_ready;
   assign bus.rf_write_en   = rf_we_q;
   assign bus.rf_write_reg  = rf_reg_q;
   assign bus.rf_write_data = rf_data_q;
   assign bus.busy_vec      = busy_q;
   assign bus.wb_err        = wb_err_q;
endmodule
